// File: rtl/regfile_if.sv
// Decode/writeback bus of the register file: packed read ports, issue marking,
// writeback and the status outputs (busy flags, pending count, a0 view).
interface regfile_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int READ_PORTS    = 2
);
    logic [READ_PORTS*ADDRESS_WIDTH-1:0] rd_addr;
    logic [READ_PORTS*DATA_WIDTH-1:0]    rd_data;
    logic [READ_PORTS-1:0]               rd_busy;
    logic                                issue_en;
    logic [ADDRESS_WIDTH-1:0]            issue_addr;
    logic                                wb_en;
    logic [ADDRESS_WIDTH-1:0]            wb_addr;
    logic [DATA_WIDTH-1:0]               wb_data;
    logic [ADDRESS_WIDTH:0]              pending_cnt;
    logic [DATA_WIDTH-1:0]               a0;

    modport master (
        output rd_addr, issue_en, issue_addr, wb_en, wb_addr, wb_data,
        input  rd_data, rd_busy, pending_cnt, a0
    );

    modport slave (
        input  rd_addr, issue_en, issue_addr, wb_en, wb_addr, wb_data,
        output rd_data, rd_busy, pending_cnt, a0
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with hardwired x0 and a per-register pending scoreboard.
// Define REGFILE_BYPASS_EN for write-first reads; the default is read-first.
module regfile_scoreboard #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int READ_PORTS    = 2
) (
    input logic      clk,
    input logic      rst,
    regfile_if.slave bus
);
    localparam int DEPTH    = 2 ** ADDRESS_WIDTH;
    localparam int A0_INDEX = 10;

    logic [DATA_WIDTH-1:0]    regs [DEPTH];
    logic [DEPTH-1:0]         pending;
    logic [DEPTH-1:0]         pending_next;
    logic [ADDRESS_WIDTH:0]   pop_next;
    logic [ADDRESS_WIDTH:0]   pending_cnt_q;
    logic [ADDRESS_WIDTH-1:0] raddr       [READ_PORTS];
    logic [DATA_WIDTH-1:0]    rdata_next  [READ_PORTS];
    logic [READ_PORTS*DATA_WIDTH-1:0] rd_data_q;
    logic [READ_PORTS-1:0]            rd_busy_q;

    logic wb_fire;
    logic issue_fire;

    assign wb_fire    = bus.wb_en && (bus.wb_addr != '0);
    assign issue_fire = bus.issue_en && (bus.issue_addr != '0);

    // Clear is applied before set so a same-cycle issue to the written register wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        pending_next = pending;
        if (wb_fire)
            pending_next[bus.wb_addr] = 1'b0;
        if (issue_fire)
            pending_next[bus.issue_addr] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_comb begin
        pop_next = '0;
        for (int r = 0; r < DEPTH; r++)
            pop_next = pop_next + {{ADDRESS_WIDTH{1'b0}}, pending_next[r]};
    end

    always_comb begin
        for (int i = 0; i < READ_PORTS; i++) begin
            raddr[i]      = bus.rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            rdata_next[i] = (raddr[i] == '0) ? '0 : regs[raddr[i]];
`ifdef REGFILE_BYPASS_EN
            if (wb_fire && (bus.wb_addr == raddr[i]))
                rdata_next[i] = bus.wb_data;
`endif
        end
    end

    // Busy flags sample the post-update scoreboard so same-cycle issue/wb is visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the register array is reset explicitly because reset state is architecturally visible here.
            for (int r = 0; r < DEPTH; r++)
                regs[r] <= '0;
            pending       <= '0;
            pending_cnt_q <= '0;
            rd_data_q     <= '0;
            rd_busy_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
            if (wb_fire)
                regs[bus.wb_addr] <= bus.wb_data;
            pending       <= pending_next;
            pending_cnt_q <= pop_next;
            for (int i = 0; i < READ_PORTS; i++) begin
                rd_data_q[i*DATA_WIDTH +: DATA_WIDTH] <= rdata_next[i];
                rd_busy_q[i]                          <= pending_next[raddr[i]];
            end
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.rd_busy     = rd_busy_q;
    assign bus.pending_cnt = pending_cnt_q;

    generate
        if (DEPTH > A0_INDEX) begin : g_a0
            assign bus.a0 = regs[A0_INDEX];
        end else begin : g_no_a0
            assign bus.a0 = '0;
        end
    endgenerate
endmodule
